// File: rtl/imm_gen_pipe.sv
// Pipelined RISC-V immediate generator: decodes the immediate for the selected format
// and queues it, with an illegal-select flag, in a 2-entry valid/ready output FIFO.
module imm_gen_pipe #(
   parameter int XLEN  = 32,
   parameter int DEPTH = 2
) (
   input  logic            CLK,
   input  logic            RST,
   input  logic [31:0]     INSTR,
   input  logic [2:0]      ImmSrc,
   input  logic            IN_VALID,
   output logic            IN_READY,
   output logic [XLEN-1:0] ImmExt,
   output logic            IMM_ERR,
   output logic            OUT_VALID,
   input  logic            OUT_READY
);

   // Handshake: a transfer happens on a rising CLK edge when valid and ready are both high
   // on that side; IN_READY depends only on registered occupancy, never on OUT_READY.

   logic [XLEN-1:0] immNext;
   logic            errNext;
   logic [XLEN-1:0] immBuf [2];
   logic            errBuf [2];
   logic            headPtr;
   logic            tailPtr;
   logic [1:0]      count;
   logic            push;
   logic            pop;
   logic            unusedOpcode;

   assign unusedOpcode = ^INSTR[6:0];

   always_comb begin
      immNext = '0;
      errNext = 1'b0;
      case (ImmSrc)
         3'b000: immNext = {{(XLEN-12){INSTR[31]}}, INSTR[31:20]};
         3'b001: immNext = {{(XLEN-12){INSTR[31]}}, INSTR[31:25], INSTR[11:7]};
         3'b010: immNext = {{(XLEN-13){INSTR[31]}}, INSTR[31], INSTR[7], INSTR[30:25],
                            INSTR[11:8], 1'b0};
         3'b011: immNext = {{(XLEN-21){INSTR[31]}}, INSTR[31], INSTR[19:12], INSTR[20],
                            INSTR[30:21], 1'b0};
         3'b100: begin
            // Fill everything with the sign first so XLEN=32 needs no zero-width replication.
            immNext       = {XLEN{INSTR[31]}};
            immNext[31:0] = {INSTR[31:12], 12'b0};
         end
         3'b101: immNext = XLEN'(INSTR[19:15]);
         default: errNext = 1'b1;
      endcase
   end

   assign IN_READY  = (count != 2'(DEPTH));
   assign OUT_VALID = (count != 2'd0);
   assign push      = IN_VALID && IN_READY;
   assign pop       = OUT_VALID && OUT_READY;
   assign ImmExt    = immBuf[headPtr];
   assign IMM_ERR   = errBuf[headPtr];

   always_ff @(posedge CLK) begin
      if (RST) begin
         count     <= 2'd0;
         headPtr   <= 1'b0;
         tailPtr   <= 1'b0;
         immBuf[0] <= '0;
         immBuf[1] <= '0;
         errBuf[0] <= 1'b0;
         errBuf[1] <= 1'b0;
      end else begin
         if (push) begin
            immBuf[tailPtr] <= immNext;
            errBuf[tailPtr] <= errNext;
            tailPtr         <= ~tailPtr;
         end
         if (pop) begin
            headPtr <= ~headPtr;
         end
         case ({push, pop})
            2'b10:   count <= count + 2'd1;
            2'b01:   count <= count - 2'd1;
            default: count <= count;
         endcase
      end
   end

endmodule

// File: tb/tb_imm_gen_pipe.sv
// Bench for imm_gen_pipe: directed vectors into a scoreboard queue, drained by
// negedge monitors, covering an XLEN=32 and an XLEN=64 instance.
module tb_imm_gen_pipe;

   logic        CLK;
   logic        RST;
   logic [31:0] INSTR;
   logic [2:0]  ImmSrc;
   logic        IN_VALID;
   logic        IN_READY;
   logic [31:0] ImmExt;
   logic        IMM_ERR;
   logic        OUT_VALID;
   logic        OUT_READY;

   logic [31:0] instr64;
   logic [2:0]  immSrc64;
   logic        inValid64;
   logic        inReady64;
   logic [63:0] immExt64;
   logic        immErr64;
   logic        outValid64;
   logic        outReady64;

   logic [32:0] exp_q[$];
   logic [64:0] exp64_q[$];
   int          total = 0;
   int          bad = 0;

   imm_gen_pipe #(.XLEN(32), .DEPTH(2)) dut (
      .CLK(CLK), .RST(RST), .INSTR(INSTR), .ImmSrc(ImmSrc), .IN_VALID(IN_VALID),
      .IN_READY(IN_READY), .ImmExt(ImmExt), .IMM_ERR(IMM_ERR), .OUT_VALID(OUT_VALID),
      .OUT_READY(OUT_READY)
   );

   imm_gen_pipe #(.XLEN(64), .DEPTH(2)) dut64 (
      .CLK(CLK), .RST(RST), .INSTR(instr64), .ImmSrc(immSrc64), .IN_VALID(inValid64),
      .IN_READY(inReady64), .ImmExt(immExt64), .IMM_ERR(immErr64), .OUT_VALID(outValid64),
      .OUT_READY(outReady64)
   );

   // clock / reset
   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   initial begin
      #500000;
      $display("FAIL watchdog: got timeout want finish");
      $fatal(1, "watchdog");
   end

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h want %h", name, act, exp);
      end
   endtask

   // monitors: a pop happens at the next posedge whenever valid && ready at the negedge
   always @(negedge CLK) begin
      if (!RST && OUT_VALID && OUT_READY) begin
         if (exp_q.size() == 0) begin
            check("unexpected_out32", {31'b0, IMM_ERR, ImmExt}, 64'hDEAD);
         end else begin
            logic [32:0] e;
            e = exp_q.pop_front();
            check("imm32", 64'(ImmExt), 64'(e[31:0]));
            check("err32", 64'(IMM_ERR), 64'(e[32]));
         end
      end
   end

   always @(negedge CLK) begin
      if (!RST && outValid64 && outReady64) begin
         if (exp64_q.size() == 0) begin
            check("unexpected_out64", immExt64, 64'hDEAD);
         end else begin
            logic [64:0] e;
            e = exp64_q.pop_front();
            check("imm64", immExt64, e[63:0]);
            check("err64", 64'(immErr64), 64'(e[64]));
         end
      end
   end

   // drivers: called at posedge+#1, return at the next posedge+#1
   task automatic drive_one(input logic [31:0] instr, input logic [2:0] src,
                            input logic [32:0] exp, output bit accepted);
      INSTR    = instr;
      ImmSrc   = src;
      IN_VALID = 1'b1;
      @(negedge CLK);
      accepted = IN_READY;
      if (accepted) exp_q.push_back(exp);
      @(posedge CLK); #1;
      IN_VALID = 1'b0;
   endtask

   task automatic drive64(input logic [31:0] instr, input logic [2:0] src,
                          input logic [64:0] exp);
      int n;
      instr64   = instr;
      immSrc64  = src;
      inValid64 = 1'b1;
      n = 0;
      @(negedge CLK);
      while (!inReady64 && n < 50) begin
         @(negedge CLK);
         n++;
      end
      check("in_ready64", 64'(inReady64), 64'd1);
      if (inReady64) exp64_q.push_back(exp);
      @(posedge CLK); #1;
      inValid64 = 1'b0;
   endtask

   task automatic wait_drain();
      for (int i = 0; i < 50 && exp_q.size() != 0; i++) @(posedge CLK);
      @(posedge CLK); #1;
      check("drain32", 64'(exp_q.size()), 64'd0);
      check("empty32", 64'(OUT_VALID), 64'd0);
   endtask

   logic [31:0] vecInstr [6] = '{32'hFFF00093, 32'hFE112E23, 32'hFE000EE3,
                                 32'h0010006F, 32'h123450B7, 32'h000FD073};
   logic [2:0]  vecSrc   [6] = '{3'b000, 3'b001, 3'b010, 3'b011, 3'b100, 3'b101};
   logic [31:0] vecExp   [6] = '{32'hFFFFFFFF, 32'hFFFFFFFC, 32'hFFFFFFFC,
                                 32'h00000800, 32'h12345000, 32'h0000001F};

   initial begin
      bit acc;
      RST = 1'b1; IN_VALID = 1'b0; INSTR = '0; ImmSrc = '0; OUT_READY = 1'b1;
      inValid64 = 1'b0; instr64 = '0; immSrc64 = '0; outReady64 = 1'b1;
      repeat (2) @(posedge CLK);
      #1;
      check("rst_out_valid", 64'(OUT_VALID), 64'd0);
      check("rst_imm", 64'(ImmExt), 64'd0);
      check("rst_err", 64'(IMM_ERR), 64'd0);
      check("rst_in_ready", 64'(IN_READY), 64'd1);
      RST = 1'b0;
      @(posedge CLK); #1;

      // every format, one push at a time, visible one edge later
      for (int i = 0; i < 6; i++) begin
         drive_one(vecInstr[i], vecSrc[i], {1'b0, vecExp[i]}, acc);
         check("single_accept", 64'(acc), 64'd1);
         check("single_latency", 64'(OUT_VALID), 64'd1);
      end
      wait_drain();

      // illegal selects, then a legal entry clears the flag
      drive_one(32'hDEADBEEF, 3'b110, {1'b1, 32'h0}, acc);
      check("err_flag", 64'(IMM_ERR), 64'd1);
      check("err_valid", 64'(OUT_VALID), 64'd1);
      check("err_imm", 64'(ImmExt), 64'd0);
      drive_one(32'hFFF00093, 3'b000, {1'b0, 32'hFFFFFFFF}, acc);
      drive_one(32'h12345678, 3'b111, {1'b1, 32'h0}, acc);
      wait_drain();

      // backpressure: third push refused while full
      OUT_READY = 1'b0;
      drive_one(32'h123450B7, 3'b100, {1'b0, 32'h12345000}, acc);
      check("bp_acc1", 64'(acc), 64'd1);
      drive_one(32'h000FD073, 3'b101, {1'b0, 32'h0000001F}, acc);
      check("bp_acc2", 64'(acc), 64'd1);
      check("bp_full_ready", 64'(IN_READY), 64'd0);
      drive_one(32'hFFF00093, 3'b000, {1'b0, 32'hFFFFFFFF}, acc);
      check("bp_acc3_refused", 64'(acc), 64'd0);
      check("bp_head_held", 64'(ImmExt), 64'h12345000);
      OUT_READY = 1'b1;
      wait_drain();
      drive_one(32'hFFF00093, 3'b000, {1'b0, 32'hFFFFFFFF}, acc);
      check("bp_represent", 64'(acc), 64'd1);
      wait_drain();

      // streaming push+pop at occupancy 1
      drive_one(32'h00000037, 3'b100, {1'b0, 32'h0}, acc);
      for (int i = 1; i <= 10; i++) begin
         drive_one({20'(i), 12'h037}, 3'b100, {1'b0, 20'(i), 12'h000}, acc);
         check("stream_ready", 64'(acc), 64'd1);
         check("stream_valid", 64'(OUT_VALID), 64'd1);
      end
      check("stream_ready_end", 64'(IN_READY), 64'd1);
      wait_drain();

      // reset while full, with a push offered in the reset cycle
      OUT_READY = 1'b0;
      drive_one(32'h123450B7, 3'b100, {1'b0, 32'h12345000}, acc);
      drive_one(32'hFFF00093, 3'b000, {1'b0, 32'hFFFFFFFF}, acc);
      check("pre_rst_full", 64'(IN_READY), 64'd0);
      exp_q.delete();
      INSTR = 32'hFFF00093; ImmSrc = 3'b000; IN_VALID = 1'b1; RST = 1'b1;
      @(posedge CLK); #1;
      RST = 1'b0; IN_VALID = 1'b0;
      check("mid_rst_valid", 64'(OUT_VALID), 64'd0);
      check("mid_rst_imm", 64'(ImmExt), 64'd0);
      check("mid_rst_err", 64'(IMM_ERR), 64'd0);
      check("mid_rst_ready", 64'(IN_READY), 64'd1);
      OUT_READY = 1'b1;
      @(posedge CLK); #1;
      check("rst_no_capture", 64'(OUT_VALID), 64'd0);

      // XLEN=64 instance
      drive64(32'hFFF00093, 3'b000, {1'b0, 64'hFFFFFFFFFFFFFFFF});
      drive64(32'h800000B7, 3'b100, {1'b0, 64'hFFFFFFFF80000000});
      drive64(32'h000FD073, 3'b101, {1'b0, 64'h000000000000001F});
      drive64(32'h00000000, 3'b110, {1'b1, 64'h0});
      for (int i = 0; i < 50 && exp64_q.size() != 0; i++) @(posedge CLK);
      @(posedge CLK); #1;
      check("drain64", 64'(exp64_q.size()), 64'd0);
      check("empty64", 64'(outValid64), 64'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
